branch_target_buffer: RTL

- Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters. It replaces the single-entry, 1-bit-history branch cache.
- Sits in IF: predicts next PC for the fetch address.
- Trained from EX when a branch or jump resolves.
- Supports single-cycle flush for fence or context reset.

---
 rtl/branch_target_buffer_pkg.sv | 14 +
 rtl/branch_target_buffer_sat_counter.sv | 22 ++
 rtl/branch_target_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared types and constants for the branch target buffer.
package branch_target_buffer_pkg;

  typedef enum bit [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } BTB_Ctr_Enum;

  // Instructions are word aligned, so the low PC bits never index the table
  localparam int BTB_INSTR_ALIGN = 2;

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Next-state function of the 2-bit saturating direction counter.
module btb_sat_counter
  import branch_target_buffer_pkg::*;
(
  input  BTB_Ctr_Enum ctr,
  input  logic        taken,
  input  logic        jump,
  output BTB_Ctr_Enum next_ctr
);

  always_comb begin
    next_ctr = ctr;
    if (jump) begin
      next_ctr = ST;
    end else if (taken) begin
      next_ctr = (ctr == ST) ? ST : BTB_Ctr_Enum'(ctr + 2'd1);
    end else begin
      next_ctr = (ctr == SNT) ? SNT : BTB_Ctr_Enum'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Optional statistics counters are enabled with BTB_STATS_EN.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_next_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_jump,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
  input  logic            flush
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int IDX_LO = BTB_INSTR_ALIGN;
  localparam int TAG_LO = IDX_W + BTB_INSTR_ALIGN;

  typedef struct packed {
    logic              v;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   ta;
    BTB_Ctr_Enum       ctr;
  } entry_t;

  entry_t mem [ENTRIES];

  logic [IDX_W-1:0] lu_idx;
  logic [TAG_W-1:0] lu_tag;
  entry_t           lu_entry;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  entry_t           up_entry;
  logic             up_hit;
  BTB_Ctr_Enum      up_next_ctr;

  assign lu_idx   = if_pc[IDX_LO +: IDX_W];
  assign lu_tag   = if_pc[TAG_LO +: TAG_W];
  assign lu_entry = mem[lu_idx];
  assign up_idx   = upd_pc[IDX_LO +: IDX_W];
  assign up_tag   = upd_pc[TAG_LO +: TAG_W];
  assign up_entry = mem[up_idx];
  assign up_hit   = up_entry.v && (up_entry.tag == up_tag);

  // Lookup reads pre-update state; reset masks any stale valid bits
  always_comb begin
    pred_hit     = !rst && lu_entry.v && (lu_entry.tag == lu_tag);
    pred_taken   = pred_hit && lu_entry.ctr[1];
    pred_next_pc = if_pc + {{(XLEN-3){1'b0}}, 3'b100};
    if (pred_taken) begin
      pred_next_pc = lu_entry.ta;
    end else begin
      pred_next_pc = if_pc + {{(XLEN-3){1'b0}}, 3'b100};
    end
  end

  btb_sat_counter u_sat_counter (
    .ctr      (up_entry.ctr),
    .taken    (upd_taken),
    .jump     (upd_jump),
    .next_ctr (up_next_ctr)
  );

  // Table state: reset beats flush, flush beats update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '{v: 1'b0, tag: '0, ta: '0, ctr: WNT};
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i].v <= 1'b0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        mem[up_idx].ctr <= up_next_ctr;
        if (upd_taken) begin
          mem[up_idx].ta <= upd_target;
        end
      end else if (upd_taken || upd_jump) begin
        mem[up_idx] <= '{v: 1'b1, tag: up_tag, ta: upd_target,
                         ctr: (upd_jump ? ST : WT)};
      end
    end
  end

`ifdef BTB_STATS_EN
  // Free-running wrapping statistics; flush leaves them alone
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups <= 32'd0;
      stat_hits    <= 32'd0;
      stat_mispred <= 32'd0;
    end else begin
      stat_lookups <= stat_lookups + 32'd1;
      stat_hits    <= stat_hits + {31'd0, pred_hit};
      stat_mispred <= stat_mispred + {31'd0, (upd_valid && upd_mispredict)};
    end
  end

  logic unused;
  assign unused = ^{if_pc, upd_pc, lu_entry};
`else
  logic unused;
  assign unused = ^{if_pc, upd_pc, lu_entry, upd_mispredict};
`endif

endmodule
